mic_clk_sequencer: RTL and testbench
====================================

// Module: mic_clk_sequencer
// PURPOSE
//  Power-up/recovery sequencer and timing generator for the MEMS mic array, in the 60 MHz PLL domain.
//  Waits for a stable PLL lock, then releases mic reset and starts the SCK/WS clocks.
//  Holds mic_ready low for a settle period of WS frames before raising it.
//  On loss of lock, stops the clocks and restarts the sequence; downstream capture logic qualifies data with mic_ready.
// PARAMETERS
//  SCK_DIV        30  clk_in cycles per SCK period; even, >=2 (60 MHz/30 = 2 MHz)
//  WS_DIV         64  SCK periods per WS frame; even, >=2 (2 MHz/64 = 31.25 kHz)
//  SETTLE_FRAMES  2   WS frames counted in SETTLE before mic_ready rises; >=1
//  LOCK_FILTER    16  consecutive synced-lock-high cycles required; >=1
// PORTS
//  clk_in          in   1  60 MHz system clock; only clock
//  rst_n           in   1  synchronous active-low reset
//  pll_lock        in   1  raw PLL lock, asynchronous; 2-FF synchronised internally
//  enable          in   1  level; 1 = run sequence, 0 = shut down
//  mic_sck         out  1  registered mic bit clock
//  mic_ws          out  1  registered word select; 0 = first half-frame, 1 = second half
//  sck_rise        out  1  1-cycle pulse, same cycle mic_sck goes 0->1
//  frame_start     out  1  1-cycle pulse, same cycle the bit counter wraps WS_DIV-1 -> 0
//  mic_rst_n       out  1  mic-side reset, active low
//  mic_ready       out  1  high only in RUN
//  state           out  2  OFF=00 WAIT_LOCK=01 SETTLE=10 RUN=11
// BEHAVIOUR
//  Reset values: state=OFF; mic_sck=0, mic_ws=0, sck_rise=0, frame_start=0, mic_rst_n=0, mic_ready=0; all counters 0; sync FFs 0.
//  Lock sync: lock_s = 2nd FF; adds 2 cycles latency.
//  Counters: sck_cnt 0..SCK_DIV-1, bit_cnt 0..WS_DIV-1, lock_cnt, settle_cnt. All run only in SETTLE/RUN.
//  Clocks: sck_cnt increments each cycle and wraps at SCK_DIV-1.
//   At sck_cnt==SCK_DIV/2-1: mic_sck<=1, sck_rise<=1.
//   At sck_cnt==SCK_DIV-1: mic_sck<=0 and bit_cnt advances (wraps at WS_DIV-1).
//   mic_sck high exactly SCK_DIV/2 cycles per period.
//  WS: mic_ws<=1 when the new bit_cnt >= WS_DIV/2, else 0. Changes only on the SCK falling edge.
//   frame_start pulses on the bit_cnt wrap to 0.
//  FSM:
//   OFF: clocks 0, mic_rst_n=0. enable=1 -> WAIT_LOCK.
//   WAIT_LOCK: clocks 0, mic_rst_n=0. lock_cnt++ while lock_s=1; lock_s=0 clears lock_cnt.
//    lock_cnt==LOCK_FILTER-1 with lock_s=1 -> SETTLE; counters cleared on entry.
//   SETTLE: mic_rst_n=1, clocks running. settle_cnt++ per frame_start.
//    SETTLE_FRAMES-th frame_start -> RUN.
//   RUN: mic_ready=1, clocks free-running.
//  Exits (evaluated every cycle):
//   enable=0 in any state -> OFF next cycle. Takes priority over lock loss.
//   lock_s=0 in SETTLE/RUN -> WAIT_LOCK next cycle. No glitch filtering on loss.
//   On either exit: mic_sck, mic_ws, mic_ready forced 0 and mic_rst_n=0 the same edge; all counters cleared. Clocks are truncated, never completed.
//  The first SCK period after entering SETTLE starts from sck_cnt=0, bit_cnt=0, mic_ws=0.
//  rst_n=0 mid-operation: all state and outputs return to reset values at the next edge.
// CONFIGURATION
//  MIC_SEQ_STATUS_EN defined: adds output lock_loss_cnt [7:0] and input clr_status.
//   lock_loss_cnt increments on each SETTLE/RUN -> WAIT_LOCK transition and saturates at 255.
//   clr_status=1 clears it; a clear wins over a simultaneous increment. Reset value 0.
//  Not defined: those ports and the logic are absent; all other behaviour is identical.
// TESTING (SCK_DIV=30, WS_DIV=64, SETTLE_FRAMES=2, LOCK_FILTER=16)
//  Reset, enable=1, lock=1 from cycle 0 -> state=SETTLE after 2+16 cycles.
//   Then mic_rst_n=1; first sck_rise 15 cycles later; mic_sck period 30; frame_start every 1920 cycles.
//  Lock pulses <16 cycles -> state stays WAIT_LOCK and mic_sck stays 0.
//  Continuing from SETTLE -> mic_ready=1 on the cycle after the 2nd frame_start.
//   mic_ws=1 for exactly 960 cycles per frame, aligned to SCK falling edges.
//  Lock drop in RUN -> 3 cycles later state=WAIT_LOCK, mic_sck=0, mic_ready=0, mic_rst_n=0.
//   Relock -> full resequence.
//  enable=0 and lock drop in the same cycle -> state=OFF; with MIC_SEQ_STATUS_EN, lock_loss_cnt unchanged.
//  With MIC_SEQ_STATUS_EN, 300 lock losses -> lock_loss_cnt=255; clr_status -> 0.
//   rst_n=0 mid-RUN -> all outputs 0 next edge.

Source files
------------

// File: rtl/mic_clk_sequencer_if.sv
// Control and clock bundle between the mic clock sequencer (master) and the capture side (slave).
// The MIC_SEQ_STATUS_EN macro adds the lock-loss status counter and its clear input.
interface mic_clk_sequencer_if;
    logic       enable;
    logic       pll_lock;
    logic       mic_sck;
    logic       mic_ws;
    logic       sck_rise;
    logic       frame_start;
    logic       mic_rst_n;
    logic       mic_ready;
    logic [1:0] state;
`ifdef MIC_SEQ_STATUS_EN
    logic       clr_status;
    logic [7:0] lock_loss_cnt;

    modport master (
        input  enable, pll_lock, clr_status,
        output mic_sck, mic_ws, sck_rise, frame_start, mic_rst_n, mic_ready, state, lock_loss_cnt
    );
    modport slave (
        output enable, pll_lock, clr_status,
        input  mic_sck, mic_ws, sck_rise, frame_start, mic_rst_n, mic_ready, state, lock_loss_cnt
    );
`else
    modport master (
        input  enable, pll_lock,
        output mic_sck, mic_ws, sck_rise, frame_start, mic_rst_n, mic_ready, state
    );
    modport slave (
        output enable, pll_lock,
        input  mic_sck, mic_ws, sck_rise, frame_start, mic_rst_n, mic_ready, state
    );
`endif
endinterface

// File: rtl/mic_clk_sequencer.sv
// Power-up/recovery sequencer and SCK/WS generator for the MEMS mic array (60 MHz PLL domain).
// Define MIC_SEQ_STATUS_EN to build the saturating lock-loss counter with clr_status.
module mic_clk_sequencer #(
    parameter int SCK_DIV       = 30,
    parameter int WS_DIV        = 64,
    parameter int SETTLE_FRAMES = 2,
    parameter int LOCK_FILTER   = 16
) (
    input  logic                clk_in,
    input  logic                rst_n,
    mic_clk_sequencer_if.master bus
);
    localparam int SCK_W    = $clog2(SCK_DIV);
    localparam int BIT_W    = $clog2(WS_DIV);
    localparam int LOCK_W   = $clog2(LOCK_FILTER + 1);
    localparam int SETTLE_W = $clog2(SETTLE_FRAMES + 1);

    localparam logic [SCK_W-1:0]    SCK_LAST    = SCK_W'(SCK_DIV - 1);
    localparam logic [SCK_W-1:0]    SCK_HALF    = SCK_W'(SCK_DIV / 2 - 1);
    localparam logic [BIT_W-1:0]    BIT_LAST    = BIT_W'(WS_DIV - 1);
    localparam logic [BIT_W-1:0]    BIT_HALF    = BIT_W'(WS_DIV / 2);
    localparam logic [LOCK_W-1:0]   LOCK_LAST   = LOCK_W'(LOCK_FILTER - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_FRAMES - 1);

    typedef enum logic [1:0] {
        S_OFF       = 2'b00,
        S_WAIT_LOCK = 2'b01,
        S_SETTLE    = 2'b10,
        S_RUN       = 2'b11
    } state_t;

    state_t              state, state_nxt;
    logic                lock_p0, lock_p1;
    logic [SCK_W-1:0]    sck_cnt, sck_cnt_nxt;
    logic [BIT_W-1:0]    bit_cnt, bit_cnt_nxt;
    logic [LOCK_W-1:0]   lock_cnt, lock_cnt_nxt;
    logic [SETTLE_W-1:0] settle_cnt, settle_cnt_nxt;
    logic                sck_r, sck_nxt;
    logic                ws_r, ws_nxt;
    logic                rise_r, rise_nxt;
    logic                fs_r, fs_nxt;
    logic                mrst_n_r, mrst_n_nxt;
    logic                ready_r, ready_nxt;

    // Stage p0/p1: two-flop synchroniser for the asynchronous PLL lock
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            lock_p0 <= 1'b0;
            lock_p1 <= 1'b0;
        end else begin
            lock_p0 <= bus.pll_lock;
            lock_p1 <= lock_p0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state      <= S_OFF;
            sck_cnt    <= '0;
            bit_cnt    <= '0;
            lock_cnt   <= '0;
            settle_cnt <= '0;
            sck_r      <= 1'b0;
            ws_r       <= 1'b0;
            rise_r     <= 1'b0;
            fs_r       <= 1'b0;
            mrst_n_r   <= 1'b0;
            ready_r    <= 1'b0;
        end else begin
            state      <= state_nxt;
            sck_cnt    <= sck_cnt_nxt;
            bit_cnt    <= bit_cnt_nxt;
            lock_cnt   <= lock_cnt_nxt;
            settle_cnt <= settle_cnt_nxt;
            sck_r      <= sck_nxt;
            ws_r       <= ws_nxt;
            rise_r     <= rise_nxt;
            fs_r       <= fs_nxt;
            mrst_n_r   <= mrst_n_nxt;
            ready_r    <= ready_nxt;
        end
    end

    // Defaults are the stopped/cleared values, so every exit truncates the clocks on the same edge.
    always_comb begin
        state_nxt      = state;
        sck_cnt_nxt    = '0;
        bit_cnt_nxt    = '0;
        lock_cnt_nxt   = '0;
        settle_cnt_nxt = '0;
        sck_nxt        = 1'b0;
        ws_nxt         = 1'b0;
        rise_nxt       = 1'b0;
        fs_nxt         = 1'b0;
        mrst_n_nxt     = 1'b0;
        ready_nxt      = 1'b0;

        unique case (state)
            S_OFF: begin
                if (bus.enable) state_nxt = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (!bus.enable) begin
                    state_nxt = S_OFF;
                end else if (lock_p1) begin
                    if (lock_cnt == LOCK_LAST) begin
                        state_nxt  = S_SETTLE;
                        mrst_n_nxt = 1'b1;
                    end else begin
                        lock_cnt_nxt = lock_cnt + 1'b1;
                    end
                end
            end
            S_SETTLE, S_RUN: begin
                if (!bus.enable) begin
                    state_nxt = S_OFF;
                end else if (!lock_p1) begin
                    state_nxt = S_WAIT_LOCK;
                end else begin
                    mrst_n_nxt     = 1'b1;
                    sck_nxt        = sck_r;
                    ws_nxt         = ws_r;
                    bit_cnt_nxt    = bit_cnt;
                    settle_cnt_nxt = settle_cnt;
                    if (sck_cnt == SCK_LAST) begin
                        sck_nxt = 1'b0;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt_nxt = '0;
                            fs_nxt      = 1'b1;
                        end else begin
                            bit_cnt_nxt = bit_cnt + 1'b1;
                        end
                        ws_nxt = (bit_cnt_nxt >= BIT_HALF);
                    end else begin
                        sck_cnt_nxt = sck_cnt + 1'b1;
                        if (sck_cnt == SCK_HALF) begin
                            sck_nxt  = 1'b1;
                            rise_nxt = 1'b1;
                        end
                    end
                    if (state == S_SETTLE) begin
                        if (fs_r) begin
                            if (settle_cnt == SETTLE_LAST) begin
                                state_nxt      = S_RUN;
                                ready_nxt      = 1'b1;
                                settle_cnt_nxt = '0;
                            end else begin
                                settle_cnt_nxt = settle_cnt + 1'b1;
                            end
                        end
                    end else begin
                        ready_nxt = 1'b1;
                    end
                end
            end
        endcase
    end

    assign bus.mic_sck     = sck_r;
    assign bus.mic_ws      = ws_r;
    assign bus.sck_rise    = rise_r;
    assign bus.frame_start = fs_r;
    assign bus.mic_rst_n   = mrst_n_r;
    assign bus.mic_ready   = ready_r;
    assign bus.state       = state;

`ifdef MIC_SEQ_STATUS_EN
    logic [7:0] lock_loss_cnt;
    logic       lock_lost;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Mirrors the SETTLE/RUN -> WAIT_LOCK branch; a disable in the same cycle is not a loss.
    assign lock_lost = ((state == S_SETTLE) || (state == S_RUN)) && bus.enable && !lock_p1;

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            lock_loss_cnt <= 8'd0;
        end else if (bus.clr_status) begin
            lock_loss_cnt <= 8'd0;
        end else if (lock_lost) begin
            lock_loss_cnt <= sat_inc8(lock_loss_cnt);
        end
    end

    assign bus.lock_loss_cnt = lock_loss_cnt;
`endif
endmodule

// File: tb/tb_mic_clk_sequencer.sv
// Scoreboard bench for mic_clk_sequencer: stimulus queues expected events, a negedge monitor pops and compares.
// Status-counter checks are included when MIC_SEQ_STATUS_EN is defined.
module tb_mic_clk_sequencer;
    localparam int SCK_DIV   = 30;
    localparam int WS_DIV    = 64;
    localparam int FRAME     = 1920;
    localparam int RUN_LAT   = 3841;
    localparam int ST_OFF    = 0;
    localparam int ST_WAIT   = 1;
    localparam int ST_SETTLE = 2;
    localparam int ST_RUN    = 3;

    typedef struct { int cyc; int st; int rstn; int rdy; } ev_t;
    typedef struct { int cyc; int val; } edge_t;

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;
    int   cyc    = 0;
    int   nchk   = 0;
    int   nerr   = 0;
    bit   mon_en = 1'b0;

    ev_t   ev_q[$];
    edge_t sck_q[$];
    edge_t ws_q[$];
    int    fs_q[$];

    mic_clk_sequencer_if bus_if ();

    mic_clk_sequencer #(
        .SCK_DIV      (SCK_DIV),
        .WS_DIV       (WS_DIV),
        .SETTLE_FRAMES(2),
        .LOCK_FILTER  (16)
    ) dut (
        .clk_in(clk_in),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name, input int val);
        nchk++;
        nerr++;
        $display("FAIL %s: actual event value=%0d at cycle %0d, required no event", name, val, cyc);
    endtask

    task automatic at_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    // Expected clock edges for a SETTLE entry at edge e, with the sequence cut at edge x.
    task automatic push_run(input int e, input int x);
        int sck_m;
        int ws_m;
        sck_m = 0;
        ws_m  = 0;
        ev_q.push_back('{e, ST_SETTLE, 1, 0});
        if (e + RUN_LAT < x) ev_q.push_back('{e + RUN_LAT, ST_RUN, 1, 1});
        for (int t = e + 1; t < x; t++) begin
            int r;
            r = t - e;
            if (r % SCK_DIV == SCK_DIV / 2) begin
                sck_q.push_back('{t, 1});
                sck_m = 1;
            end
            if (r % SCK_DIV == 0) begin
                sck_q.push_back('{t, 0});
                sck_m = 0;
                if (r % FRAME == FRAME / 2) begin
                    ws_q.push_back('{t, 1});
                    ws_m = 1;
                end
                if (r % FRAME == 0) begin
                    ws_q.push_back('{t, 0});
                    ws_m = 0;
                    fs_q.push_back(t);
                end
            end
        end
        if (sck_m == 1) sck_q.push_back('{x, 0});
        if (ws_m == 1) ws_q.push_back('{x, 0});
    endtask

    int    m_st, m_rstn, m_rdy, m_sck, m_ws, m_rise, m_fs;
    int    p_st = 0, p_rstn = 0, p_rdy = 0, p_sck = 0, p_ws = 0;
    ev_t   m_ev;
    edge_t m_edge;
    int    m_f;

    always @(negedge clk_in) begin
        m_st   = int'(bus_if.state);
        m_rstn = int'(bus_if.mic_rst_n);
        m_rdy  = int'(bus_if.mic_ready);
        m_sck  = int'(bus_if.mic_sck);
        m_ws   = int'(bus_if.mic_ws);
        m_rise = int'(bus_if.sck_rise);
        m_fs   = int'(bus_if.frame_start);
        if (mon_en) begin
            if (m_st != p_st || m_rstn != p_rstn || m_rdy != p_rdy) begin
                if (ev_q.size() == 0) begin
                    unexpected("state_event", m_st);
                end else begin
                    m_ev = ev_q.pop_front();
                    chk("ev_cycle", cyc, m_ev.cyc);
                    chk("ev_state", m_st, m_ev.st);
                    chk("ev_mic_rst_n", m_rstn, m_ev.rstn);
                    chk("ev_mic_ready", m_rdy, m_ev.rdy);
                end
            end
            if (m_sck != p_sck) begin
                if (sck_q.size() == 0) begin
                    unexpected("sck_edge", m_sck);
                end else begin
                    m_edge = sck_q.pop_front();
                    chk("sck_edge_cycle", cyc, m_edge.cyc);
                    chk("sck_edge_value", m_sck, m_edge.val);
                end
            end
            if (m_rise == 1 || (m_sck == 1 && p_sck == 0))
                chk("sck_rise_pulse", m_rise, int'(m_sck == 1 && p_sck == 0));
            if (m_ws != p_ws) begin
                if (ws_q.size() == 0) begin
                    unexpected("ws_edge", m_ws);
                end else begin
                    m_edge = ws_q.pop_front();
                    chk("ws_edge_cycle", cyc, m_edge.cyc);
                    chk("ws_edge_value", m_ws, m_edge.val);
                end
                if (m_st == ST_SETTLE || m_st == ST_RUN)
                    chk("ws_on_sck_fall", int'(p_sck == 1 && m_sck == 0), 1);
            end
            if (m_fs == 1) begin
                if (fs_q.size() == 0) begin
                    unexpected("frame_start", m_fs);
                end else begin
                    m_f = fs_q.pop_front();
                    chk("frame_start_cycle", cyc, m_f);
                end
            end
        end
        p_st   = m_st;
        p_rstn = m_rstn;
        p_rdy  = m_rdy;
        p_sck  = m_sck;
        p_ws   = m_ws;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded its time limit at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus_if.enable   = 1'b0;
        bus_if.pll_lock = 1'b0;
`ifdef MIC_SEQ_STATUS_EN
        bus_if.clr_status = 1'b0;
`endif
        rst_n = 1'b0;

        at_cyc(3);
        chk("reset_state", int'(bus_if.state), ST_OFF);
        chk("reset_mic_sck", int'(bus_if.mic_sck), 0);
        chk("reset_mic_ws", int'(bus_if.mic_ws), 0);
        chk("reset_sck_rise", int'(bus_if.sck_rise), 0);
        chk("reset_frame_start", int'(bus_if.frame_start), 0);
        chk("reset_mic_rst_n", int'(bus_if.mic_rst_n), 0);
        chk("reset_mic_ready", int'(bus_if.mic_ready), 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        at_cyc(5);
        bus_if.enable = 1'b1;
        ev_q.push_back('{6, ST_WAIT, 0, 0});

        // Lock pulses of 10 and 15 cycles are both too short for the 16-cycle filter.
        at_cyc(10); bus_if.pll_lock = 1'b1;
        at_cyc(20); bus_if.pll_lock = 1'b0;
        at_cyc(30); bus_if.pll_lock = 1'b1;
        at_cyc(45); bus_if.pll_lock = 1'b0;
        at_cyc(50);
        chk("filter_state", int'(bus_if.state), ST_WAIT);
        chk("filter_mic_sck", int'(bus_if.mic_sck), 0);

        at_cyc(60);
        bus_if.pll_lock = 1'b1;
        push_run(78, 4898);
        ev_q.push_back('{4898, ST_WAIT, 0, 0});
        at_cyc(78);
        chk("settle_state", int'(bus_if.state), ST_SETTLE);
        chk("settle_mic_rst_n", int'(bus_if.mic_rst_n), 1);
        at_cyc(3919);
        chk("run_mic_ready", int'(bus_if.mic_ready), 1);

        at_cyc(4895);
        bus_if.pll_lock = 1'b0;
        at_cyc(4898);
        chk("loss_state", int'(bus_if.state), ST_WAIT);
        chk("loss_mic_sck", int'(bus_if.mic_sck), 0);
        chk("loss_mic_ready", int'(bus_if.mic_ready), 0);
        chk("loss_mic_rst_n", int'(bus_if.mic_rst_n), 0);
`ifdef MIC_SEQ_STATUS_EN
        at_cyc(4900);
        chk("loss_cnt_first", int'(bus_if.lock_loss_cnt), 1);
`endif

        at_cyc(4903);
        bus_if.pll_lock = 1'b1;
        push_run(4921, 5421);
        ev_q.push_back('{5421, ST_OFF, 0, 0});
        at_cyc(5418); bus_if.pll_lock = 1'b0;
        at_cyc(5420); bus_if.enable = 1'b0;
        at_cyc(5421);
        chk("disable_wins_state", int'(bus_if.state), ST_OFF);
`ifdef MIC_SEQ_STATUS_EN
        chk("disable_wins_loss_cnt", int'(bus_if.lock_loss_cnt), 1);
`endif

        at_cyc(5430);
        bus_if.enable = 1'b1;
        ev_q.push_back('{5431, ST_WAIT, 0, 0});
        at_cyc(5440);
        bus_if.pll_lock = 1'b1;
        push_run(5458, 9310);
        ev_q.push_back('{9310, ST_OFF, 0, 0});
        at_cyc(9309);
        rst_n           = 1'b0;
        bus_if.enable   = 1'b0;
        bus_if.pll_lock = 1'b0;
        at_cyc(9310);
        chk("midrun_rst_state", int'(bus_if.state), ST_OFF);
        chk("midrun_rst_mic_sck", int'(bus_if.mic_sck), 0);
        chk("midrun_rst_mic_ws", int'(bus_if.mic_ws), 0);
        chk("midrun_rst_sck_rise", int'(bus_if.sck_rise), 0);
        chk("midrun_rst_frame_start", int'(bus_if.frame_start), 0);
        chk("midrun_rst_mic_rst_n", int'(bus_if.mic_rst_n), 0);
        chk("midrun_rst_mic_ready", int'(bus_if.mic_ready), 0);
        at_cyc(9312);
        rst_n = 1'b1;

`ifdef MIC_SEQ_STATUS_EN
        at_cyc(9320);
        chk("loss_cnt_after_reset", int'(bus_if.lock_loss_cnt), 0);
        bus_if.enable = 1'b1;
        ev_q.push_back('{9321, ST_WAIT, 0, 0});
        for (int i = 0; i < 300; i++) begin
            int c;
            c = 9330 + 21 * i;
            at_cyc(c);
            bus_if.pll_lock = 1'b1;
            ev_q.push_back('{c + 18, ST_SETTLE, 1, 0});
            ev_q.push_back('{c + 21, ST_WAIT, 0, 0});
            at_cyc(c + 18);
            bus_if.pll_lock = 1'b0;
        end
        at_cyc(15632);
        chk("loss_cnt_saturated", int'(bus_if.lock_loss_cnt), 255);
        at_cyc(15635); bus_if.clr_status = 1'b1;
        at_cyc(15636); bus_if.clr_status = 1'b0;
        at_cyc(15637);
        chk("loss_cnt_clear", int'(bus_if.lock_loss_cnt), 0);
        at_cyc(15640);
        bus_if.pll_lock = 1'b1;
        ev_q.push_back('{15658, ST_SETTLE, 1, 0});
        ev_q.push_back('{15661, ST_WAIT, 0, 0});
        at_cyc(15658); bus_if.pll_lock = 1'b0;
        at_cyc(15660); bus_if.clr_status = 1'b1;
        at_cyc(15661); bus_if.clr_status = 1'b0;
        at_cyc(15662);
        chk("clear_beats_increment", int'(bus_if.lock_loss_cnt), 0);
`endif

        at_cyc(cyc + 10);
        chk("ev_queue_left", ev_q.size(), 0);
        chk("sck_queue_left", sck_q.size(), 0);
        chk("ws_queue_left", ws_q.size(), 0);
        chk("fs_queue_left", fs_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
